// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_ctrl (+ half_subtractor cell)
// Purpose  : Bit-serial unsigned a - b, one bit per clock, LSB first,
//            built on two half_subtractor cells and an OR gate.
// Revision : 1.0 - initial release
// ============================================================================

module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic br
);
    assign d  = x ^ y;
    assign br = ~x & y;
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0]    c_ST_IDLE = 2'd0;
    localparam logic [1:0]    c_ST_RUN  = 2'd1;
    localparam logic [1:0]    c_ST_DONE = 2'd2;
    localparam logic [CW-1:0] c_LAST    = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bin;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_d1;
    logic             w_br1;
    logic             w_d;
    logic             w_br2;
    logic             w_bnext;
    logic [WIDTH-1:0] w_res_next;

    half_subtractor u_hs1 (.x(r_a[0]), .y(r_b[0]), .d(w_d1), .br(w_br1));
    half_subtractor u_hs2 (.x(w_d1),   .y(r_bin),  .d(w_d),  .br(w_br2));

    assign w_bnext = w_br1 | w_br2;

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_d;
        end else begin : g_res_wn
            assign w_res_next = {w_d, r_res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_res <= w_res_next;
                    r_bin <= w_bnext;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == c_LAST) begin
                        r_diff  <= w_res_next;
                        r_bout  <= w_bnext;
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);
    assign diff       = r_diff;
    assign borrow_out = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor_ctrl
// Purpose  : Scoreboard bench for the serial subtractor (WIDTH=8 and WIDTH=1).
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_subtractor_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;

    logic start1 = 1'b0;
    logic a1 = 1'b0;
    logic b1 = 1'b0;
    logic busy1, done1, diff1, bout1;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bout1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int nchk = 0;
    int nfail = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        int           at;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: unsigned subtraction modulo 2^W, borrow when a < b
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int at);
        exp_t   e;
        longint m;
        m    = longint'(1) << W;
        e.d  = W'((longint'(x) - longint'(y) + m) % m);
        e.br = (x < y);
        e.at = at;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("borrow_out", 32'(borrow_out), 32'(e.br));
                chk("done_cycle", 32'(cyc), 32'(e.at));
                chk("busy_in_done", 32'(busy), 32'd1);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        wait_idle();
        start = 1'b1;
        a     = x;
        b     = y;
        q.push_back(model(x, y, cyc + 1 + W));
        @(posedge clk); #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        logic x1, y1;

        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(8'h5A, 8'h3C);
        bc = 0;
        repeat (12) begin
            if (busy) bc++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", 32'(bc), 32'd9);

        issue(8'h00, 8'h01);
        issue(8'hFF, 8'hFF);
        issue(8'h80, 8'h7F);
        drain();

        // start pulse during RUN must be ignored
        issue(8'h22, 8'h11);
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1; a = 8'h10; b = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        repeat (12) begin @(posedge clk); #1; end
        chk("diff_hold", 32'(diff), 32'h11);

        // start held high: back-to-back jobs every W+2 cycles
        wait_idle();
        start = 1'b1; a = 8'h05; b = 8'h07;
        for (int k = 0; k < 4; k++) q.push_back(model(8'h05, 8'h07, cyc + 1 + W + k * (W + 2)));
        drain();
        start = 1'b0;
        repeat (W + 4) begin @(posedge clk); #1; end

        // asynchronous reset mid-job
        issue(8'h5A, 8'h3C);
        drain();
        chk("pre_reset_diff", 32'(diff), 32'h1E);
        issue(8'h33, 8'h44);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_diff", 32'(diff), 32'd0);
        chk("arst_borrow", 32'(borrow_out), 32'd0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(8'h03, 8'h02);
        drain();

        repeat (20) begin
            issue(W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        drain();

        // WIDTH=1 instance: exhaustive operand pairs
        for (int i = 0; i < 4; i++) begin
            x1 = (i >= 2);
            y1 = (i % 2 == 1);
            start1 = 1'b1; a1 = x1; b1 = y1;
            @(posedge clk); #1;
            start1 = 1'b0;
            @(negedge clk);
            chk("w1_done_early", 32'(done1), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("w1_done", 32'(done1), 32'd1);
            chk("w1_diff", 32'(diff1), 32'((int'(x1) - int'(y1) + 2) % 2));
            chk("w1_borrow", 32'(bout1), 32'(x1 < y1));
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

`default_nettype wire
